button_encoder: RTL and testbench
=================================

Name: button_encoder

Overview:
Front end of the game's key path. It takes five raw, asynchronous push-button levels and produces the one-cycle button codes that drive the cursor-move and game-control logic on button_o. It synchronises and debounces the inputs, accepts only clean single-key presses, and optionally auto-repeats held direction keys. It sits between the board pins and the play-state logic.

Parameters:
DEBOUNCE_CYCLES, 1_000_000, consecutive stable synchronised cycles before the debounced vector updates (20 ms at 50 MHz); minimum 2.
REPEAT_DELAY, 25_000_000, cycles from the press event to the first auto-repeat pulse (used only with BUTTON_REPEAT_EN).
REPEAT_PERIOD, 5_000_000, cycles between later auto-repeat pulses (used only with BUTTON_REPEAT_EN).

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous, active-low reset
btn_raw_i  input  5  raw key levels, active-high, asynchronous: [0]=up, [1]=down, [2]=left, [3]=right, [4]=center
button_o  output  5  one-hot button code, valid for exactly one cycle per event; 5'b00000 = no event
held_o  output  1  1 while a single debounced key is held and accepted

Behaviour:
- Reset: rst_n sampled low at a clk edge clears every register: sync flops, candidate, counters, debounced vector db=0, FSM=IDLE, button_o=0, held_o=0. All keys are treated as released after reset.
- Reset mid-press or mid-repeat abandons the event. A key still held after reset release counts as a new press once it has debounced.
- Sync: two-flop synchroniser per bit gives sync_q.
- Debounce: shared candidate register cand plus counter cnt, ceil(log2(DEBOUNCE_CYCLES)) bits.
  - Each cycle, if sync_q != cand: cand<=sync_q, cnt<=0.
  - Else, if cnt==DEBOUNCE_CYCLES-1: db<=cand and cnt holds.
  - Else: cnt<=cnt+1.
  - A glitch shorter than DEBOUNCE_CYCLES never reaches db.
- FSM, operating on db, with button_o registered:
  - IDLE: if db has exactly one bit set, go to PRESSED and set button_o<=db for one cycle. If db has two or more bits set, go to LOCKED with no event. If db==0, stay in IDLE.
  - PRESSED: held_o=1. If db==0, go to IDLE. If db changes to any other nonzero value (second key, or key swap without release), go to LOCKED with no event.
  - LOCKED: no output. Stays until db==0, then goes to IDLE. A full release is always required before the next accepted press.
- Latency: raw edge sampled by the synchroniser at rising edge 1 gives button_o high after rising edge DEBOUNCE_CYCLES+4, for exactly one cycle.
- button_o is 0 in every cycle other than an event cycle; held_o is 0 outside PRESSED/REPEAT.
- Release never produces an event.

Optional Feature:
BUTTON_REPEAT_EN
- Defined:
  - For direction keys (bits 0-3) only, the FSM adds a state REPEAT and a counter rcnt of ceil(log2(max(REPEAT_DELAY,REPEAT_PERIOD))) bits.
  - In PRESSED with db unchanged, a pulse equal to db is emitted REPEAT_DELAY cycles after the press-event cycle, and the FSM moves to REPEAT.
  - In REPEAT, a pulse is emitted every REPEAT_PERIOD cycles.
  - Release goes to IDLE; a db change goes to LOCKED; both clear rcnt.
  - The center key never repeats.
- Undefined: REPEAT state, rcnt and the repeat parameters are absent. One event per press only.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=6):
1. Reset, then btn_raw_i=5'b00100 held 30 cycles -> button_o=5'b00100 for one cycle after edge 8, 0 otherwise; held_o=1 from the same edge.
2. btn_raw_i=5'b00001 pulsed for 3 cycles, then 0 -> button_o stays 0, held_o stays 0.
3. Hold 5'b01000, then add bit0 (5'b01001), then release all, then press 5'b10000 -> one 5'b01000 event, no event for the combined state, one 5'b10000 event after release plus debounce.
4. Press 5'b00011 simultaneously -> no event, LOCKED. Release to 0, press 5'b00010 -> single 5'b00010 event.
5. Hold 5'b00010, assert rst_n=0 for one edge while held -> button_o=0 and held_o=0 after the reset edge. After release, a new 5'b00010 event occurs DEBOUNCE_CYCLES+4 edges later.
6. BUTTON_REPEAT_EN defined, hold 5'b00100 for 50 cycles after its press event -> pulses at +20, +26, +32, +38, +44, +50 cycles. Holding 5'b10000 -> a single event only.

Source files
------------

// File: rtl/button_encoder.sv
// button_encoder: five raw push-button levels in, one-cycle one-hot button
// codes out. The path is a two-flop synchroniser, then a shared debouncer,
// then a press FSM that only accepts clean single-key presses.
// Optional build macro BUTTON_REPEAT_EN adds auto-repeat for held direction
// keys (bits 0-3); the center key (bit 4) never repeats.
// Handshake: button_o is a pure one-cycle strobe, with no ready/back-pressure.
// A nonzero button_o is the event. held_o is a level that is high while an
// accepted single key stays down.
module button_encoder #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
`ifdef BUTTON_REPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] btn_raw_i,
  output logic [4:0] button_o,
  output logic       held_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef BUTTON_REPEAT_EN
  localparam int R_MAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RCNT_W = (R_MAX > 1) ? $clog2(R_MAX) : 1;
  localparam logic [RCNT_W-1:0] R_DELAY_MAX  = RCNT_W'(REPEAT_DELAY - 1);
  localparam logic [RCNT_W-1:0] R_PERIOD_MAX = RCNT_W'(REPEAT_PERIOD - 1);
`endif

  // The state encoding is kept fixed so a checker can bind to state_q directly.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESSED = 2'd1,
    S_LOCKED  = 2'd2
`ifdef BUTTON_REPEAT_EN
    ,
    S_REPEAT  = 2'd3
`endif
  } state_e;

  logic [4:0]       meta_q;
  logic [4:0]       sync_q;
  logic [4:0]       cand_q;
  logic [CNT_W-1:0] cnt_q;
  logic [4:0]       db_q;
  logic             db_one_hot;

  state_e           state_q, state_d;
  logic [4:0]       key_q, key_d;
  logic [4:0]       button_q, button_d;
`ifdef BUTTON_REPEAT_EN
  logic [RCNT_W-1:0] rcnt_q, rcnt_d;
`endif

  // Two-flop synchroniser for the asynchronous key levels.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= btn_raw_i;
      sync_q <= meta_q;
    end
  end

  // Shared debouncer: db_q takes the candidate only after it has been stable
  // for DEBOUNCE_CYCLES cycles. Any change restarts the count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cand_q <= '0;
      cnt_q  <= '0;
      db_q   <= '0;
    end else if (sync_q != cand_q) begin
      cand_q <= sync_q;
      cnt_q  <= '0;
    end else if (cnt_q == CNT_MAX) begin
      db_q   <= cand_q;
    end else begin
      cnt_q  <= cnt_q + 1'b1;
    end
  end

  assign db_one_hot = (db_q != 5'd0) && ((db_q & (db_q - 5'd1)) == 5'd0);

  // Press FSM state, accepted key and registered event strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      key_q    <= '0;
      button_q <= '0;
`ifdef BUTTON_REPEAT_EN
      rcnt_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      key_q    <= key_d;
      button_q <= button_d;
`ifdef BUTTON_REPEAT_EN
      rcnt_q   <= rcnt_d;
`endif
    end
  end

  // Next-state and event logic. A full release is required after any
  // multi-key or changed-key situation before the next press is accepted.
  always_comb begin
    state_d  = state_q;
    key_d    = key_q;
    button_d = '0;
`ifdef BUTTON_REPEAT_EN
    rcnt_d   = rcnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (db_one_hot) begin
          state_d  = S_PRESSED;
          key_d    = db_q;
          button_d = db_q;
`ifdef BUTTON_REPEAT_EN
          rcnt_d   = '0;
`endif
        end else if (db_q != 5'd0) begin
          state_d = S_LOCKED;
        end
      end
      S_PRESSED: begin
        if (db_q == 5'd0) begin
          state_d = S_IDLE;
`ifdef BUTTON_REPEAT_EN
          rcnt_d  = '0;
`endif
        end else if (db_q != key_q) begin
          state_d = S_LOCKED;
`ifdef BUTTON_REPEAT_EN
          rcnt_d  = '0;
`endif
        end
`ifdef BUTTON_REPEAT_EN
        else if (!key_q[4]) begin
          if (rcnt_q == R_DELAY_MAX) begin
            button_d = key_q;
            state_d  = S_REPEAT;
            rcnt_d   = '0;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
`endif
      end
      S_LOCKED: begin
        if (db_q == 5'd0) begin
          state_d = S_IDLE;
        end
      end
`ifdef BUTTON_REPEAT_EN
      S_REPEAT: begin
        if (db_q == 5'd0) begin
          state_d = S_IDLE;
          rcnt_d  = '0;
        end else if (db_q != key_q) begin
          state_d = S_LOCKED;
          rcnt_d  = '0;
        end else if (rcnt_q == R_PERIOD_MAX) begin
          button_d = key_q;
          rcnt_d   = '0;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign button_o = button_q;
`ifdef BUTTON_REPEAT_EN
  assign held_o   = (state_q == S_PRESSED) || (state_q == S_REPEAT);
`else
  assign held_o   = (state_q == S_PRESSED);
`endif

endmodule

// File: tb/tb_button_encoder.sv
// Testbench for button_encoder with short debounce/repeat times.
// Stimulus pushes the expected event code and its cycle into the queues.
// A negedge monitor pops an entry for every nonzero button_o.
module tb_button_encoder;

  localparam int DB = 4;
`ifdef BUTTON_REPEAT_EN
  localparam int RD = 20;
  localparam int RP = 6;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] btn_raw_i;
  logic [4:0] button_o;
  logic       held_o;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  logic [4:0] exp_q[$];
  int         exp_cyc_q[$];
  logic [4:0] mon_code;
  int         mon_cyc;
  int         t0;

  // Clock and cycle counter. cyc equals the number of rising edges seen.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  button_encoder #(
    .DEBOUNCE_CYCLES(DB)
`ifdef BUTTON_REPEAT_EN
    ,
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
`endif
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_raw_i(btn_raw_i),
    .button_o (button_o),
    .held_o   (held_o)
  );

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic expect_event(input int at, input logic [4:0] code);
    exp_q.push_back(code);
    exp_cyc_q.push_back(at);
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every nonzero button_o must match the next expected event.
  always @(negedge clk) begin
    if (button_o !== 5'b00000) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL spurious_event: got %b expected none at cycle %0d", button_o, cyc);
      end else begin
        mon_code = exp_q.pop_front();
        mon_cyc  = exp_cyc_q.pop_front();
        if (button_o !== mon_code || cyc != mon_cyc) begin
          bad++;
          $display("FAIL event: got %b at cycle %0d expected %b at cycle %0d",
                   button_o, cyc, mon_code, mon_cyc);
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    btn_raw_i = 5'b00000;
    wait_n(3);
    check("reset_button", button_o, 5'b00000);
    check("reset_held", {4'b0, held_o}, 5'b00000);
    rst_n = 1'b1;
    wait_n(10);

    // 1: single left press, held 30 cycles
    t0 = cyc;
    btn_raw_i = 5'b00100;
    expect_event(t0 + DB + 4, 5'b00100);
`ifdef BUTTON_REPEAT_EN
    expect_event(t0 + DB + 4 + RD, 5'b00100);
    expect_event(t0 + DB + 4 + RD + RP, 5'b00100);
`endif
    wait_n(DB + 3);
    check("t1_held_before_event", {4'b0, held_o}, 5'b00000);
    wait_n(1);
    check("t1_held_at_event", {4'b0, held_o}, 5'b00001);
    wait_n(30 - (DB + 4));
    check("t1_held_long", {4'b0, held_o}, 5'b00001);
    btn_raw_i = 5'b00000;
    wait_n(DB + 6);
    check("t1_held_after_release", {4'b0, held_o}, 5'b00000);
    wait_n(5);

    // 2: 3-cycle glitch must never reach the debounced vector
    btn_raw_i = 5'b00001;
    wait_n(3);
    btn_raw_i = 5'b00000;
    for (int i = 0; i < 12; i++) begin
      check("t2_glitch_held", {4'b0, held_o}, 5'b00000);
      wait_n(1);
    end

    // 3: right, then right+up (locked), release, then center
    t0 = cyc;
    btn_raw_i = 5'b01000;
    expect_event(t0 + DB + 4, 5'b01000);
    wait_n(12);
    check("t3_right_held", {4'b0, held_o}, 5'b00001);
    btn_raw_i = 5'b01001;
    wait_n(12);
    check("t3_combo_locked", {4'b0, held_o}, 5'b00000);
    btn_raw_i = 5'b00000;
    wait_n(12);
    check("t3_released", {4'b0, held_o}, 5'b00000);
    t0 = cyc;
    btn_raw_i = 5'b10000;
    expect_event(t0 + DB + 4, 5'b10000);
    wait_n(12);
    check("t3_center_held", {4'b0, held_o}, 5'b00001);
    btn_raw_i = 5'b00000;
    wait_n(12);
    check("t3_center_released", {4'b0, held_o}, 5'b00000);

    // 4: simultaneous up+down locks, then a clean down press
    btn_raw_i = 5'b00011;
    wait_n(12);
    check("t4_double_locked", {4'b0, held_o}, 5'b00000);
    btn_raw_i = 5'b00000;
    wait_n(12);
    t0 = cyc;
    btn_raw_i = 5'b00010;
    expect_event(t0 + DB + 4, 5'b00010);
    wait_n(12);
    check("t4_down_held", {4'b0, held_o}, 5'b00001);

    // 5: reset while down is held; key re-debounces as a new press
    t0 = cyc;
    rst_n = 1'b0;
    wait_n(1);
    rst_n = 1'b1;
    check("t5_button_after_reset", button_o, 5'b00000);
    check("t5_held_after_reset", {4'b0, held_o}, 5'b00000);
    expect_event(t0 + 1 + DB + 4, 5'b00010);
    wait_n(DB + 5);
    check("t5_held_new_press", {4'b0, held_o}, 5'b00001);
    btn_raw_i = 5'b00000;
    wait_n(12);
    check("t5_released", {4'b0, held_o}, 5'b00000);

`ifdef BUTTON_REPEAT_EN
    // 6: auto-repeat on a held direction key, none on center
    t0 = cyc;
    btn_raw_i = 5'b00100;
    expect_event(t0 + DB + 4, 5'b00100);
    for (int k = 0; k < 6; k++) begin
      expect_event(t0 + DB + 4 + RD + k * RP, 5'b00100);
    end
    wait_n(DB + 4 + 46);
    check("t6_repeat_held", {4'b0, held_o}, 5'b00001);
    btn_raw_i = 5'b00000;
    wait_n(15);
    check("t6_repeat_released", {4'b0, held_o}, 5'b00000);
    t0 = cyc;
    btn_raw_i = 5'b10000;
    expect_event(t0 + DB + 4, 5'b10000);
    wait_n(60);
    check("t6_center_held", {4'b0, held_o}, 5'b00001);
    btn_raw_i = 5'b00000;
    wait_n(15);
`endif

    wait_n(20);
    while (exp_q.size() != 0) begin
      total++;
      bad++;
      mon_code = exp_q.pop_front();
      mon_cyc  = exp_cyc_q.pop_front();
      $display("FAIL missed_event: got none expected %b at cycle %0d", mon_code, mon_cyc);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
